// File: rtl/roulette_pkg.sv
// Shared constants for the multi-digit roulette: segment decode table,
// blank pattern and FSM state encoding.
package roulette_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off
  localparam logic [7:0] SEG_CODES [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    COAST = 2'd2
  } state_t;

endpackage

// File: rtl/roulette_mux_bcd_digit_chain.sv
// DIGITS x base-BASE counter; a single inc ripples carry through every digit
// in the same clock, and all-(BASE-1) wraps to all-zero.
module bcd_digit_chain #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   digits
);
  import roulette_pkg::*;

  localparam logic [3:0] LAST = 4'(BASE - 1);

  logic [4*DIGITS-1:0] digits_d;

  always_comb begin
    logic carry;
    digits_d = digits;
    carry    = inc;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (digits[i*4 +: 4] == LAST) begin
          digits_d[i*4 +: 4] = 4'd0;
        end else begin
          digits_d[i*4 +: 4] = digits[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digits <= '0;
    else     digits <= digits_d;
  end

endmodule

// File: rtl/roulette_mux.sv
// Multi-digit roulette: spins while the button is held, coasts with a slowing
// step rate after release, and drives a multiplexed common-segment display.
module roulette_mux #(
  parameter int DIGITS      = 4,
  parameter int BASE        = 10,
  parameter int PRE_DIV     = 50000,
  parameter int SCAN_DIV    = 1000,
  parameter int COAST_STEPS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_in,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] dig_sel,
  output logic              busy
);
  import roulette_pkg::*;

  localparam int PW = (PRE_DIV > 1)          ? $clog2(PRE_DIV)         : 1;
  localparam int SW = (SCAN_DIV > 1)         ? $clog2(SCAN_DIV)        : 1;
  localparam int IW = (DIGITS > 1)           ? $clog2(DIGITS)          : 1;
  localparam int CW = (COAST_STEPS + 2 > 1)  ? $clog2(COAST_STEPS + 2) : 1;

  logic                sw_m, sw_s;
  logic [PW-1:0]       pre_cnt;
  logic                tick;
  state_t              state, state_d;
  logic [CW-1:0]       k, k_d, w, w_d;
  logic                advance;
  logic [4*DIGITS-1:0] digit_vec;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= 1'b0;
      sw_s <= 1'b0;
    end else begin
      sw_m <= sw_in;
      sw_s <= sw_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             pre_cnt <= '0;
    else if (pre_cnt == PW'(PRE_DIV - 1)) pre_cnt <= '0;
    else                                 pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PW'(PRE_DIV - 1));

  // A tick on a transition clock is swallowed: only the steady-state
  // branches below ever raise advance.
  always_comb begin
    state_d = state;
    k_d     = k;
    w_d     = w;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (sw_s) state_d = SPIN;
      end
      SPIN: begin
        if (!sw_s) begin
          state_d = COAST;
          k_d     = '0;
          w_d     = CW'(2);
        end else if (tick) begin
          advance = 1'b1;
        end
      end
      COAST: begin
        if (sw_s) begin
          state_d = SPIN;
        end else if (tick) begin
          if (w == CW'(1)) begin
            advance = 1'b1;
            if (k == CW'(COAST_STEPS - 1)) begin
              state_d = IDLE;
            end else begin
              k_d = k + CW'(1);
              w_d = k + CW'(3);
            end
          end else begin
            w_d = w - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      w     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      k     <= k_d;
      w     <= w_d;
      busy  <= (state_d != IDLE);
    end
  end

  bcd_digit_chain #(
    .DIGITS (DIGITS),
    .BASE   (BASE)
  ) u_chain (
    .clk    (clk),
    .rst    (rst),
    .inc    (advance),
    .digits (digit_vec)
  );

  // Segment bus and digit enable load on the same edge so they never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_out  <= SEG_BLANK;
      dig_sel  <= '1;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      seg_out <= SEG_CODES[digit_vec[int'(scan_idx)*4 +: 4]];
      dig_sel <= ~(DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_roulette_mux.sv
// Directed bench for roulette_mux with a queue of expected digit values
// compared after every advance tick.
module tb_roulette_mux;
  localparam int DIGITS      = 2;
  localparam int BASE        = 10;
  localparam int PRE_DIV     = 4;
  localparam int SCAN_DIV    = 2;
  localparam int COAST_STEPS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sw_in;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] dig_sel;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  // Own copy of the prescaler phase, derived only from reset and clock count
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  roulette_mux #(
    .DIGITS      (DIGITS),
    .BASE        (BASE),
    .PRE_DIV     (PRE_DIV),
    .SCAN_DIV    (SCAN_DIV),
    .COAST_STEPS (COAST_STEPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .seg_out (seg_out),
    .dig_sel (dig_sel),
    .busy    (busy)
  );

  function automatic logic [7:0] bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next clock edge that consumes a tick
  task automatic tick_edge();
    while (cyc % PRE_DIV != PRE_DIV - 1) step();
    step();
  endtask

  task automatic push_range(input int from, input int to);
    for (int v = from; v <= to; v++) exp_q.push_back(bcd(v));
  endtask

  task automatic push_val(input int v, input int times);
    for (int i = 0; i < times; i++) exp_q.push_back(bcd(v));
  endtask

  task automatic run_ticks(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      tick_edge();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s: observed=%h expected=<queue empty>", tag, dut.digit_vec);
      end else begin
        e = exp_q.pop_front();
        check(tag, dut.digit_vec, e);
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max_edges, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < max_edges) begin
      step();
      n++;
    end
    check(tag, {7'b0, busy}, {7'b0, lvl});
  endtask

  task automatic show(input logic [1:0] sel, input logic [7:0] seg_exp, input string tag);
    int n;
    n = 0;
    while (dig_sel !== sel && n < 8) begin
      step();
      n++;
    end
    check({tag, "_sel"}, {6'b0, dig_sel}, {6'b0, sel});
    check({tag, "_seg"}, seg_out, seg_exp);
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = 1'b0;
    repeat (3) step();
    check("rst_seg",    seg_out, 8'hFF);
    check("rst_sel",    {6'b0, dig_sel}, 8'h03);
    check("rst_busy",   {7'b0, busy}, 8'h00);
    check("rst_digits", dut.digit_vec, 8'h00);

    rst = 1'b0;
    step();
    check("scan0_sel", {6'b0, dig_sel}, 8'h02);
    check("scan0_seg", seg_out, 8'h03);

    // Spin for 12 ticks after SPIN entry
    sw_in = 1'b1;
    wait_busy(1'b1, 3, "sync_busy");
    push_range(1, 12);
    run_ticks(12, "spin");

    // Coast: advances after 2, 3, 4 ticks, then idle
    sw_in = 1'b0;
    push_val(12, 1); push_val(13, 3); push_val(14, 4);
    run_ticks(8, "coast");
    check("coast_busy", {7'b0, busy}, 8'h01);
    push_val(15, 1);
    run_ticks(1, "coast_end");
    check("idle_busy", {7'b0, busy}, 8'h00);

    push_val(15, 50);
    run_ticks(50, "hold");
    show(2'b10, 8'h49, "disp_d0");
    show(2'b01, 8'h9F, "disp_d1");

    // Re-press after one coast advance
    sw_in = 1'b1;
    wait_busy(1'b1, 3, "repress_busy");
    push_range(16, 25);
    run_ticks(10, "spin2");
    sw_in = 1'b0;
    push_val(25, 1); push_val(26, 1);
    run_ticks(2, "coast2");
    sw_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("resume_busy", {7'b0, busy}, 8'h01);
    end
    push_range(27, 47);
    run_ticks(21, "resume");

    // Reset mid-spin with the button still held
    rst = 1'b1;
    step();
    check("midrst_digits", dut.digit_vec, 8'h00);
    check("midrst_busy",   {7'b0, busy}, 8'h00);
    check("midrst_seg",    seg_out, 8'hFF);
    check("midrst_sel",    {6'b0, dig_sel}, 8'h03);
    rst = 1'b0;
    step();
    check("post_rst_idle", {7'b0, busy}, 8'h00);
    wait_busy(1'b1, 2, "respin_busy");

    // Full wrap: 99 -> 00 on tick 100
    push_range(1, 100);
    run_ticks(100, "wrap");
    check("wrap_q_empty", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
